// File: rtl/wcdma_pkg.sv
// Shared constants, types and helpers for the WCDMA OVSF spreader/despreader pair.
// The I/Q packing and code bit-reversal are defined here so both ends agree.
package wcdma_pkg;

  localparam int unsigned CHIP_W      = 16;
  localparam int unsigned MAX_SF_LOG2 = 8;
  localparam int unsigned ACC_W       = CHIP_W + MAX_SF_LOG2;
  localparam int unsigned IDX_W       = $clog2(MAX_SF_LOG2);

  localparam logic signed [ACC_W-1:0] SymMax = ACC_W'((1 << (CHIP_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SymMin = ~SymMax;

  typedef enum logic {StIdle, StAccum} state_e;

  // Q occupies the upper half, I the lower half.
  function automatic logic [2*CHIP_W-1:0] pack_iq(input logic [CHIP_W-1:0] i,
                                                  input logic [CHIP_W-1:0] q);
    return {q, i};
  endfunction

  function automatic logic signed [CHIP_W-1:0] get_i(input logic [2*CHIP_W-1:0] d);
    return d[CHIP_W-1:0];
  endfunction

  function automatic logic signed [CHIP_W-1:0] get_q(input logic [2*CHIP_W-1:0] d);
    return d[2*CHIP_W-1:CHIP_W];
  endfunction

  // Reverse the low l bits of k; bits at and above l come out as zero.
  function automatic logic [MAX_SF_LOG2-1:0] bitrev(input logic [MAX_SF_LOG2-1:0] k,
                                                    input logic [3:0]             l);
    logic [MAX_SF_LOG2-1:0] r;
    int                     idx;
    r = '0;
    for (int b = 0; b < int'(MAX_SF_LOG2); b++) begin
      if (b < int'(l)) begin
        idx = int'(l) - 1 - b;
        r[idx[IDX_W-1:0]] = k[b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wcdma_ovsf_code_bit.sv
// OVSF code chip generator: sign of chip n of C(2^L, k); 1 means multiply by -1.
// Combinational, shared with the spreader so both ends use the same code definition.
module wcdma_ovsf_code_bit
  import wcdma_pkg::*;
(
  input  logic [3:0]             sf_log2_i,
  input  logic [MAX_SF_LOG2-1:0] code_i,
  input  logic [MAX_SF_LOG2-1:0] chip_idx_i,
  output logic                   code_bit_o
);

  assign code_bit_o = ^(chip_idx_i & bitrev(code_i, sf_log2_i));

endmodule

// File: rtl/wcdma_ovsf_despreader.sv
// OVSF despreader: multiplies complex chips by the configured code, integrates over SF
// chips and emits one averaged complex symbol per SF chips through a one-entry output register.
module wcdma_ovsf_despreader
  import wcdma_pkg::*;
(
  input  logic                   aclk,
  input  logic                   arst,
  input  logic                   cfg_valid,
  input  logic [3:0]             cfg_sf_log2,
  input  logic [MAX_SF_LOG2-1:0] cfg_code,
  output logic                   cfg_err,
  input  logic [2*CHIP_W-1:0]    s_axis_tdata,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [2*CHIP_W-1:0]    m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   sync_err,
  output logic                   busy
);

  localparam logic [MAX_SF_LOG2:0] SfOne = (MAX_SF_LOG2 + 1)'(1);

  state_e                   state_q, state_d;
  logic [3:0]               sf_log2_q, sf_log2_d;
  logic [MAX_SF_LOG2-1:0]   code_q, code_d;
  logic [MAX_SF_LOG2-1:0]   chip_cnt_q, chip_cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                     out_valid_q, out_valid_d;
  logic [2*CHIP_W-1:0]      out_data_q, out_data_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     sync_err_q, sync_err_d;

  logic [MAX_SF_LOG2:0]     sf_full;
  logic [MAX_SF_LOG2-1:0]   sf_last, code_idx;
  logic                     at_last, cfg_ok, chip_acc, misalign, complete, code_bit;
  logic signed [ACC_W-1:0]  x_i, x_q, base_i, base_q, sum_i, sum_q;

  function automatic logic [CHIP_W-1:0] sat_sym(input logic signed [ACC_W-1:0] v);
    if (v > SymMax) return SymMax[CHIP_W-1:0];
    if (v < SymMin) return SymMin[CHIP_W-1:0];
    return v[CHIP_W-1:0];
  endfunction

  assign sf_full = SfOne << sf_log2_q;
  assign sf_last = MAX_SF_LOG2'(sf_full - SfOne);
  assign at_last = (chip_cnt_q == sf_last);
  assign cfg_ok  = (cfg_sf_log2 >= 4'd2) && (cfg_sf_log2 <= 4'(MAX_SF_LOG2));

  // Only the final chip is held back while an unread symbol occupies the output register.
  assign s_axis_tready = (state_q == StAccum) && !cfg_valid &&
                         !(out_valid_q && !m_axis_tready && at_last);
  assign chip_acc      = s_axis_tvalid && s_axis_tready;
  assign misalign      = s_axis_tuser && (chip_cnt_q != '0);
  assign complete      = !misalign && at_last;
  assign code_idx      = s_axis_tuser ? '0 : chip_cnt_q;

  wcdma_ovsf_code_bit u_code_bit (
    .sf_log2_i  (sf_log2_q),
    .code_i     (code_q),
    .chip_idx_i (code_idx),
    .code_bit_o (code_bit)
  );

  assign x_i    = ACC_W'(get_i(s_axis_tdata));
  assign x_q    = ACC_W'(get_q(s_axis_tdata));
  assign base_i = misalign ? '0 : acc_i_q;
  assign base_q = misalign ? '0 : acc_q_q;
  assign sum_i  = code_bit ? base_i - x_i : base_i + x_i;
  assign sum_q  = code_bit ? base_q - x_q : base_q + x_q;

  always_comb begin
    state_d     = state_q;
    sf_log2_d   = sf_log2_q;
    code_d      = code_q;
    chip_cnt_d  = chip_cnt_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    out_valid_d = out_valid_q && !m_axis_tready;
    out_data_d  = out_data_q;
    cfg_err_d   = 1'b0;
    sync_err_d  = 1'b0;
    if (cfg_valid) begin
      if (cfg_ok) begin
        state_d    = StAccum;
        sf_log2_d  = cfg_sf_log2;
        code_d     = cfg_code;
        chip_cnt_d = '0;
        acc_i_d    = '0;
        acc_q_d    = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (chip_acc) begin
      sync_err_d = misalign;
      if (complete) begin
        chip_cnt_d  = '0;
        acc_i_d     = '0;
        acc_q_d     = '0;
        out_valid_d = 1'b1;
        out_data_d  = pack_iq(sat_sym(sum_i >>> sf_log2_q), sat_sym(sum_q >>> sf_log2_q));
      end else begin
        chip_cnt_d = misalign ? MAX_SF_LOG2'(1) : chip_cnt_q + MAX_SF_LOG2'(1);
        acc_i_d    = sum_i;
        acc_q_d    = sum_q;
      end
    end
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      state_q     <= StIdle;
      sf_log2_q   <= '0;
      code_q      <= '0;
      chip_cnt_q  <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sf_log2_q   <= sf_log2_d;
      code_q      <= code_d;
      chip_cnt_q  <= chip_cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign cfg_err       = cfg_err_q;
  assign sync_err      = sync_err_q;
  assign busy          = (state_q == StAccum) && (chip_cnt_q != '0);

endmodule

// File: tb/tb_wcdma_ovsf_despreader.sv
// Directed bench for the OVSF despreader with hand-computed symbol values.
module tb_wcdma_ovsf_despreader;

  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_sf_log2 = '0;
  logic [7:0]  cfg_code = '0;
  logic        cfg_err;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        sync_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int sym_cnt  = 0;

  wcdma_ovsf_despreader dut (
    .aclk          (aclk),
    .arst          (arst),
    .cfg_valid     (cfg_valid),
    .cfg_sf_log2   (cfg_sf_log2),
    .cfg_code      (cfg_code),
    .cfg_err       (cfg_err),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sync_err      (sync_err),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) sym_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic configure(input logic [3:0] l, input logic [7:0] k);
    cfg_valid   = 1'b1;
    cfg_sf_log2 = l;
    cfg_code    = k;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Returns just after the edge on which the chip was accepted.
  task automatic send_chip(input int i, input int q, input logic user);
    logic ok;
    s_axis_tdata  = {q[15:0], i[15:0]};
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge aclk);
      ok = s_axis_tready;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    check_val("chip_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_n(input int n, input int i, input int q);
    for (int c = 0; c < n; c++) send_chip(i, q, 1'b0);
  endtask

  initial begin
    int   base;
    logic seen;
    int   qpat [4] = '{-1, -1, -1, -2};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check_val("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_val("rst_m_tdata", m_axis_tdata, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_val("rst_sync_err", 32'(sync_err), 32'd0);
    arst = 1'b1;
    s_axis_tvalid = 1'b1;
    tick();
    check_val("idle_s_tready", 32'(s_axis_tready), 32'd0);
    s_axis_tvalid = 1'b0;

    // SF=4, k=1: code +,+,-,-
    configure(4'd2, 8'd1);
    check_val("t1_cfg_err", 32'(cfg_err), 32'd0);
    send_chip(100, 0, 1'b1);
    send_chip(100, 0, 1'b0);
    check_val("t1_busy", 32'(busy), 32'd1);
    send_chip(-100, 0, 1'b0);
    check_val("t1_no_early", 32'(m_axis_tvalid), 32'd0);
    send_chip(-100, 0, 1'b0);
    check_val("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t1_tdata", m_axis_tdata, 32'h0000_0064);
    check_val("t1_busy_end", 32'(busy), 32'd0);
    tick();
    check_val("t1_tvalid_clr", 32'(m_axis_tvalid), 32'd0);

    // Orthogonality: k=0 and k=3 against the same I chips
    configure(4'd2, 8'd0);
    send_chip(100, 50, 1'b0);
    send_chip(100, 50, 1'b0);
    send_chip(-100, 50, 1'b0);
    send_chip(-100, 50, 1'b0);
    check_val("t2_k0_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t2_k0_tdata", m_axis_tdata, 32'h0032_0000);
    configure(4'd2, 8'd3);
    send_chip(100, 50, 1'b0);
    send_chip(100, 50, 1'b0);
    send_chip(-100, 50, 1'b0);
    send_chip(-100, 50, 1'b0);
    check_val("t2_k3_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t2_k3_tdata", m_axis_tdata, 32'h0000_0000);

    // SF=256 full-scale negative chips
    configure(4'd8, 8'd0);
    send_n(256, -32768, -32768);
    check_val("t3_k0_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t3_k0_tdata", m_axis_tdata, 32'h8000_8000);
    configure(4'd8, 8'd255);
    send_n(256, -32768, -32768);
    check_val("t3_k255_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t3_k255_tdata", m_axis_tdata, 32'h0000_0000);

    // Back-pressure: final chip of 2nd symbol stalls; Q sum -5 >>> 2 floors to -2
    configure(4'd2, 8'd0);
    m_axis_tready = 1'b0;
    base = sym_cnt;
    for (int c = 0; c < 4; c++) send_chip(40, qpat[c], 1'b0);
    for (int c = 0; c < 3; c++) send_chip(80, qpat[c], 1'b0);
    s_axis_tdata  = {16'hFFFE, 16'd80};
    s_axis_tvalid = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      if (s_axis_tready) seen = 1'b1;
    end
    check_val("t4_stall", 32'(seen), 32'd0);
    check_val("t4_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t4_hold_tdata", m_axis_tdata, 32'hFFFE_0028);
    tick();
    m_axis_tready = 1'b1;
    #1;
    check_val("t4_resume_ready", 32'(s_axis_tready), 32'd1);
    tick();
    s_axis_tvalid = 1'b0;
    check_val("t4_b_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t4_b_tdata", m_axis_tdata, 32'hFFFE_0050);
    tick();
    check_val("t4_b_clr", 32'(m_axis_tvalid), 32'd0);
    check_val("t4_sym_count", 32'(sym_cnt - base), 32'd2);

    // Realignment on chip index 2 of SF=8
    configure(4'd3, 8'd0);
    send_chip(1000, 0, 1'b1);
    check_val("t5_sync_ok", 32'(sync_err), 32'd0);
    send_chip(1000, 0, 1'b0);
    send_chip(8, 0, 1'b1);
    check_val("t5_sync_err", 32'(sync_err), 32'd1);
    send_chip(8, 0, 1'b0);
    check_val("t5_sync_pulse", 32'(sync_err), 32'd0);
    send_n(5, 8, 0);
    check_val("t5_not_yet", 32'(m_axis_tvalid), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd1);
    send_chip(8, 0, 1'b0);
    check_val("t5_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t5_tdata", m_axis_tdata, 32'h0000_0008);
    tick();

    // Illegal configs keep the old setup and any partial symbol
    configure(4'd9, 8'd5);
    check_val("t6_l9_err", 32'(cfg_err), 32'd1);
    tick();
    check_val("t6_err_pulse", 32'(cfg_err), 32'd0);
    send_n(3, 16, 0);
    configure(4'd1, 8'd0);
    check_val("t6_l1_err", 32'(cfg_err), 32'd1);
    check_val("t6_l1_busy", 32'(busy), 32'd1);
    send_n(5, 16, 0);
    check_val("t6_old_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t6_old_tdata", m_axis_tdata, 32'h0000_0010);
    tick();

    // Legal reconfig mid-symbol drops the partial but keeps the pending symbol
    m_axis_tready = 1'b0;
    send_n(8, 24, 0);
    send_n(3, 100, 0);
    configure(4'd3, 8'd0);
    check_val("t6_l3_err", 32'(cfg_err), 32'd0);
    check_val("t6_l3_busy", 32'(busy), 32'd0);
    check_val("t6_pend_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t6_pend_tdata", m_axis_tdata, 32'h0000_0018);
    m_axis_tready = 1'b1;
    tick();
    check_val("t6_pend_clr", 32'(m_axis_tvalid), 32'd0);
    send_n(7, -8, 0);
    check_val("t6_new_not_yet", 32'(m_axis_tvalid), 32'd0);
    send_chip(-8, 0, 1'b0);
    check_val("t6_new_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_val("t6_new_tdata", m_axis_tdata, 32'h0000_FFF8);
    tick();

    // Reset mid-operation discards the pending symbol
    m_axis_tready = 1'b0;
    send_n(8, 24, 0);
    send_n(2, 24, 0);
    arst = 1'b0;
    #1;
    check_val("t7_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_val("t7_rst_busy", 32'(busy), 32'd0);
    arst = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    check_val("t7_post_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_val("t7_post_ready", 32'(s_axis_tready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
